// File: rtl/dual_input_debouncer.sv
// Conditions two raw asynchronous inputs into clean synchronous levels, with
// per-channel edge pulses and a combined settled flag for the downstream FSM.
module dual_input_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic settled
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NCH   = 2;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    GO_HI     = 2'd1,
    STABLE_HI = 2'd2,
    GO_LO     = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [SYNC_STAGES-1:0] sync_d [NCH];
  state_e                 state_q [NCH];
  state_e                 state_d [NCH];
  logic [CNT_W-1:0]       cnt_q [NCH];
  logic [CNT_W-1:0]       cnt_d [NCH];
  logic [NCH-1:0]         out_q, out_d;
  logic [NCH-1:0]         rise_q, rise_d;
  logic [NCH-1:0]         fall_q, fall_d;
  logic [NCH-1:0]         raw_vec;
  logic [NCH-1:0]         s_vec;
  logic [NCH-1:0]         stable_vec;

  assign raw_vec = {raw_b, raw_a};

  // Synchronizer shift: raw enters stage 0, the last stage feeds the FSM.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], raw_vec[ch]};
      s_vec[ch]  = sync_q[ch][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < NCH; ch++) begin
        sync_q[ch]  <= '0;
        state_q[ch] <= STABLE_LO;
        cnt_q[ch]   <= '0;
      end
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        sync_q[ch]  <= sync_d[ch];
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Debounce FSM per channel; any sample disagreeing with the pending direction aborts it.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      out_d[ch]   = out_q[ch];
      rise_d[ch]  = 1'b0;
      fall_d[ch]  = 1'b0;
      case (state_q[ch])
        STABLE_LO: begin
          if (s_vec[ch]) begin
            if (DIRECT) begin
              state_d[ch] = STABLE_HI;
              out_d[ch]   = 1'b1;
              rise_d[ch]  = 1'b1;
            end else begin
              state_d[ch] = GO_HI;
              cnt_d[ch]   = CNT_ONE;
            end
          end
        end
        GO_HI: begin
          if (!s_vec[ch]) begin
            state_d[ch] = STABLE_LO;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = STABLE_HI;
            cnt_d[ch]   = '0;
            out_d[ch]   = 1'b1;
            rise_d[ch]  = 1'b1;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s_vec[ch]) begin
            if (DIRECT) begin
              state_d[ch] = STABLE_LO;
              out_d[ch]   = 1'b0;
              fall_d[ch]  = 1'b1;
            end else begin
              state_d[ch] = GO_LO;
              cnt_d[ch]   = CNT_ONE;
            end
          end
        end
        GO_LO: begin
          if (s_vec[ch]) begin
            state_d[ch] = STABLE_HI;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CNT_LAST) begin
            state_d[ch] = STABLE_LO;
            cnt_d[ch]   = '0;
            out_d[ch]   = 1'b0;
            fall_d[ch]  = 1'b1;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_ONE;
          end
        end
        default: begin
          state_d[ch] = STABLE_LO;
          cnt_d[ch]   = '0;
          out_d[ch]   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      stable_vec[ch] = (state_q[ch] == STABLE_LO) || (state_q[ch] == STABLE_HI);
    end
  end

  assign a       = out_q[0];
  assign b       = out_q[1];
  assign a_rise  = rise_q[0];
  assign a_fall  = fall_q[0];
  assign b_rise  = rise_q[1];
  assign b_fall  = fall_q[1];
  assign settled = &stable_vec;

endmodule
